// File: rtl/store_trace_fifo_pkg.sv
// Shared types and widths for the store trace tap.
package store_trace_pkg;

   typedef struct packed {
      logic [7:0]  seq;
      logic [31:0] adr;
      logic [31:0] data;
   } store_rec_t;

   localparam int SEQ_W = 8;
   localparam int OVF_W = 16;

endpackage

// File: rtl/store_trace_fifo_if.sv
// Store tap bus: CPU store strobe in, trace record valid/ready out, plus occupancy status.
interface store_trace_fifo_if #(
   parameter int DEPTH = 8
) ();
   localparam int CW = $clog2(DEPTH) + 1;

   logic                           memwrite;
   logic [31:0]                    dataadr;
   logic [31:0]                    writedata;
   logic                           out_valid;
   logic                           out_ready;
   logic [store_trace_pkg::SEQ_W-1:0] out_seq;
   logic [31:0]                    out_adr;
   logic [31:0]                    out_data;
   logic [CW-1:0]                  count;
   logic                           full;
   logic [store_trace_pkg::OVF_W-1:0] overflow_cnt;

   // master: CPU plus consumer side; slave: the trace FIFO itself
   modport master (
      output memwrite, dataadr, writedata, out_ready,
      input  out_valid, out_seq, out_adr, out_data, count, full, overflow_cnt
   );

   modport slave (
      input  memwrite, dataadr, writedata, out_ready,
      output out_valid, out_seq, out_adr, out_data, count, full, overflow_cnt
   );
endinterface

// File: rtl/store_trace_fifo_sync_fifo.sv
// Generic show-ahead FIFO; head visible in the cycle after the push, push+pop allowed when full.
module sync_fifo #(
   parameter type T     = logic [7:0],
   parameter int  DEPTH = 8,
   localparam int AW    = $clog2(DEPTH),
   localparam int CW    = AW + 1
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          push_i,
   input  logic          pop_i,
   input  T              wdat_i,
   output T              rdat_o,
   output logic [CW-1:0] count_o,
   output logic          full_o,
   output logic          empty_o
);

   T              mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push_i) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop_i)  rd_ptr_d = rd_ptr_q + AW'(1);
      if (push_i && !pop_i)      count_d = count_q + CW'(1);
      else if (pop_i && !push_i) count_d = count_q - CW'(1);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage is not reset; the count gates every read of it.
   always_ff @(posedge clk) begin
      if (!reset && push_i) mem_q[wr_ptr_q] <= wdat_i;
   end

   assign rdat_o  = mem_q[rd_ptr_q];
   assign count_o = count_q;
   assign full_o  = (count_q == CW'(DEPTH));
   assign empty_o = (count_q == '0);

endmodule

// File: rtl/store_trace_fifo.sv
// Passive tap on CPU stores: qualifies by address, tags with a sequence number, buffers in a FIFO.
// Never stalls the CPU; a store arriving while full and not draining is dropped and counted.
module store_trace_fifo
   import store_trace_pkg::*;
#(
   parameter int          DEPTH     = 8,
   parameter logic [31:0] ADDR_BASE = 32'h0000_0000,
   parameter logic [31:0] ADDR_MASK = 32'h0000_0000
) (
   input  logic              clk,
   input  logic              reset,
   store_trace_fifo_if.slave bus
);

   localparam int CW = $clog2(DEPTH) + 1;

   logic             hit, pop, push;
   logic             fifo_full, fifo_empty;
   logic [CW-1:0]    fifo_count;
   store_rec_t       wr_rec, head_rec;
   logic [SEQ_W-1:0] seq_q, seq_d;
   logic [OVF_W-1:0] ovf_q, ovf_d;

   always_comb begin
      hit    = bus.memwrite && ((bus.dataadr & ADDR_MASK) == ADDR_BASE);
      pop    = !fifo_empty && bus.out_ready;
      push   = hit && (!fifo_full || pop);
      wr_rec = '{seq: seq_q, adr: bus.dataadr, data: bus.writedata};
      // Tags advance on every hit, so a dropped store leaves a visible gap.
      seq_d  = hit ? seq_q + SEQ_W'(1) : seq_q;
      ovf_d  = ovf_q;
      if (hit && fifo_full && !pop && (ovf_q != '1)) ovf_d = ovf_q + OVF_W'(1);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         seq_q <= '0;
         ovf_q <= '0;
      end else begin
         seq_q <= seq_d;
         ovf_q <= ovf_d;
      end
   end

   sync_fifo #(
      .T     (store_rec_t),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk     (clk),
      .reset   (reset),
      .push_i  (push),
      .pop_i   (pop),
      .wdat_i  (wr_rec),
      .rdat_o  (head_rec),
      .count_o (fifo_count),
      .full_o  (fifo_full),
      .empty_o (fifo_empty)
   );

   assign bus.out_valid    = !fifo_empty;
   assign bus.out_seq      = fifo_empty ? '0 : head_rec.seq;
   assign bus.out_adr      = fifo_empty ? '0 : head_rec.adr;
   assign bus.out_data     = fifo_empty ? '0 : head_rec.data;
   assign bus.count        = fifo_count;
   assign bus.full         = fifo_full;
   assign bus.overflow_cnt = ovf_q;

endmodule

// File: tb/tb_store_trace_fifo.sv
// Bench for store_trace_fifo: queue-based reference model driven by directed and random stores.
module tb_store_trace_fifo;
   import store_trace_pkg::*;

   localparam int DEPTH = 8;

   logic clk = 1'b0;
   logic reset = 1'b1;
   int   checks = 0;
   int   failures = 0;

   always #5 clk = ~clk;

   store_trace_fifo_if #(.DEPTH(DEPTH)) if_def ();
   store_trace_fifo_if #(.DEPTH(DEPTH)) if_msk ();

   store_trace_fifo #(.DEPTH(DEPTH)) u_def (
      .clk   (clk),
      .reset (reset),
      .bus   (if_def)
   );

   store_trace_fifo #(
      .DEPTH     (DEPTH),
      .ADDR_BASE (32'hFFFF_0000),
      .ADDR_MASK (32'hFFFF_0000)
   ) u_msk (
      .clk   (clk),
      .reset (reset),
      .bus   (if_msk)
   );

   store_rec_t m_q[$];
   int         m_seq = 0;
   int         m_ovf = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_model(input string tag);
      store_rec_t h;
      h = '0;
      if (m_q.size() > 0) h = m_q[0];
      chk({tag, ".valid"}, 32'(if_def.out_valid), 32'(m_q.size() > 0));
      chk({tag, ".count"}, 32'(if_def.count), 32'(m_q.size()));
      chk({tag, ".full"}, 32'(if_def.full), 32'(m_q.size() == DEPTH));
      chk({tag, ".ovf"}, 32'(if_def.overflow_cnt), 32'(m_ovf));
      chk({tag, ".seq"}, 32'(if_def.out_seq), 32'(h.seq));
      chk({tag, ".adr"}, if_def.out_adr, h.adr);
      chk({tag, ".data"}, if_def.out_data, h.data);
   endtask

   // Called at a falling edge: drive, let one rising edge pass, then compare at the next falling edge.
   task automatic step(input string tag, input logic mw, input logic [31:0] adr,
                       input logic [31:0] dat, input logic rdy);
      bit was_full, do_pop;
      if_def.memwrite  = mw;
      if_def.dataadr   = adr;
      if_def.writedata = dat;
      if_def.out_ready = rdy;
      was_full = (m_q.size() == DEPTH);
      do_pop   = (m_q.size() > 0) && rdy;
      if (do_pop) void'(m_q.pop_front());
      if (mw) begin
         if (!was_full || do_pop) m_q.push_back('{seq: 8'(m_seq), adr: adr, data: dat});
         else if (m_ovf < 65535) m_ovf++;
         m_seq = (m_seq + 1) % 256;
      end
      @(posedge clk);
      @(negedge clk);
      if_def.memwrite  = 1'b0;
      if_def.out_ready = 1'b0;
      check_model(tag);
   endtask

   task automatic do_reset(input logic mw);
      reset = 1'b1;
      if_def.memwrite  = mw;
      if_def.dataadr   = 32'h0000_0100;
      if_def.writedata = 32'hDEAD_BEEF;
      @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      if_def.memwrite = 1'b0;
      m_q.delete();
      m_seq = 0;
      m_ovf = 0;
      check_model("reset");
   endtask

   initial begin
      int prev_seq;
      if_def.memwrite = 0; if_def.dataadr = 0; if_def.writedata = 0; if_def.out_ready = 0;
      if_msk.memwrite = 0; if_msk.dataadr = 0; if_msk.writedata = 0; if_msk.out_ready = 0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      do_reset(1'b0);
      chk("reset.count0", 32'(if_def.count), 32'd0);
      chk("reset.msk_valid0", 32'(if_msk.out_valid), 32'd0);

      // Single store then a single pop
      step("first", 1'b1, 32'h54, 32'd7, 1'b0);
      chk("first.seq0", 32'(if_def.out_seq), 32'd0);
      chk("first.adr", if_def.out_adr, 32'h54);
      chk("first.data", if_def.out_data, 32'd7);
      step("pop1", 1'b0, 32'h0, 32'h0, 1'b1);
      chk("pop1.valid0", 32'(if_def.out_valid), 32'd0);
      chk("pop1.data0", if_def.out_data, 32'd0);

      // Masked instance: only the high-page store qualifies and it takes tag 0
      if_msk.memwrite = 1'b1; if_msk.dataadr = 32'h50; if_msk.writedata = 32'h11;
      @(posedge clk); @(negedge clk);
      chk("msk.miss_count", 32'(if_msk.count), 32'd0);
      if_msk.dataadr = 32'hFFFF_0004; if_msk.writedata = 32'hA5;
      @(posedge clk); @(negedge clk);
      if_msk.memwrite = 1'b0;
      chk("msk.count", 32'(if_msk.count), 32'd1);
      chk("msk.seq", 32'(if_msk.out_seq), 32'd0);
      chk("msk.adr", if_msk.out_adr, 32'hFFFF_0004);
      chk("msk.data", if_msk.out_data, 32'hA5);
      check_model("idle");

      // Overflow: 10 stores with no drain
      do_reset(1'b0);
      for (int i = 0; i < 10; i++) begin
         step("fill", 1'b1, 32'h1000 + 32'(i * 4), $urandom, 1'b0);
         if (i == 7) chk("fill.full_at8", 32'(if_def.full), 32'd1);
      end
      chk("fill.ovf2", 32'(if_def.overflow_cnt), 32'd2);
      chk("fill.head0", 32'(if_def.out_seq), 32'd0);
      step("fullpp", 1'b1, 32'h2000, 32'h77, 1'b1);
      chk("fullpp.count8", 32'(if_def.count), 32'd8);
      chk("fullpp.ovf2", 32'(if_def.overflow_cnt), 32'd2);
      chk("fullpp.head1", 32'(if_def.out_seq), 32'd1);
      for (int i = 0; i < 7; i++) step("drain", 1'b0, 32'h0, 32'h0, 1'b1);
      chk("drain.tag10", 32'(if_def.out_seq), 32'd10);
      step("drain_last", 1'b0, 32'h0, 32'h0, 1'b1);

      // Streaming: tags run 0..255 then wrap without gaps
      do_reset(1'b0);
      prev_seq = -1;
      for (int i = 0; i < 300; i++) begin
         step("stream", 1'b1, $urandom, $urandom, 1'b1);
         chk("stream.cnt_le1", 32'(if_def.count <= 1), 32'd1);
         if (prev_seq >= 0) chk("stream.nogap", 32'(if_def.out_seq), 32'((prev_seq + 1) % 256));
         prev_seq = int'(if_def.out_seq);
      end

      // Random traffic with random consumer backpressure
      for (int i = 0; i < 400; i++)
         step("rand", 1'($urandom_range(0, 9) < 8), $urandom, $urandom, 1'($urandom_range(0, 9) < 3));

      // Reset with buffered records and a concurrent store
      for (int i = 0; i < 20 && m_q.size() > 0; i++) step("flush", 1'b0, 32'h0, 32'h0, 1'b1);
      for (int i = 0; i < 5; i++) step("buf5", 1'b1, $urandom, $urandom, 1'b0);
      chk("buf5.count", 32'(if_def.count), 32'd5);
      do_reset(1'b1);
      chk("rst.count0", 32'(if_def.count), 32'd0);
      chk("rst.valid0", 32'(if_def.out_valid), 32'd0);
      chk("rst.ovf0", 32'(if_def.overflow_cnt), 32'd0);
      step("post_rst", 1'b1, 32'h88, 32'h99, 1'b0);
      chk("post_rst.seq0", 32'(if_def.out_seq), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
